// File: rtl/sacc_stage_pkg.sv
// Shared types and saturation bounds for the saturating frame accumulator.
// The bound helpers return 64-bit values; callers keep the low bits they need.
package sacc_stage_pkg;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DONE  = 1'b1
   } state_t;

   function automatic logic signed [63:0] sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/sacc_stage_if.sv
// Sample-in / result-out handshake bundle of the accumulator stage.
// Both sides use valid/ready: a beat moves on a rising edge where valid && ready.
interface sacc_stage_if #(
   parameter int DATAWIDTH = 8,
   parameter int ACCWIDTH  = 16
);
   logic                        clr;
   logic                        in_valid;
   logic                        in_ready;
   logic signed [DATAWIDTH-1:0] sum;
   logic                        out_valid;
   logic                        out_ready;
   logic signed [ACCWIDTH-1:0]  acc_out;
   logic                        ovf;

   modport master (
      output clr, in_valid, sum, out_ready,
      input  in_ready, out_valid, acc_out, ovf
   );

   modport slave (
      input  clr, in_valid, sum, out_ready,
      output in_ready, out_valid, acc_out, ovf
   );
endinterface

// File: rtl/sacc_stage_sat_clamp.sv
// Combinational signed clamp from W+1 bits down to W bits.
// ovf is raised whenever either bound had to be applied.
module sat_clamp
   import sacc_stage_pkg::*;
#(
   parameter int W = 16
) (
   input  logic signed [W:0]   din,
   output logic signed [W-1:0] dout,
   output logic                ovf
);
   localparam logic signed [63:0] MAX64 = sat_max(W);
   localparam logic signed [63:0] MIN64 = sat_min(W);
   localparam logic signed [W:0]  MAXV  = MAX64[W:0];
   localparam logic signed [W:0]  MINV  = MIN64[W:0];

   logic pos_ovf;
   logic neg_ovf;

   always_comb begin
      pos_ovf = (din > MAXV);
      neg_ovf = (din < MINV);
      ovf     = pos_ovf | neg_ovf;
      if (pos_ovf) begin
         dout = MAXV[W-1:0];
      end else if (neg_ovf) begin
         dout = MINV[W-1:0];
      end else begin
         dout = din[W-1:0];
      end
   end
endmodule

// File: rtl/sacc_stage.sv
// Saturating frame accumulator: sums COUNT signed samples, then holds the
// clamped total and a sticky overflow flag until the consumer takes it.
module sacc_stage
   import sacc_stage_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int ACCWIDTH  = 16,
   parameter int COUNT     = 4
) (
   input  logic        Clk,
   input  logic        Rst,
   sacc_stage_if.slave bus,
   output state_t      state_dbg
);
   localparam int            CW   = $clog2(COUNT + 1);
   localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

   state_t                      state_q, state_d;
   logic signed [ACCWIDTH-1:0]  acc_q, acc_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic                        ovf_q, ovf_d;

   logic signed [ACCWIDTH:0]    sum_ext;
   logic signed [ACCWIDTH:0]    acc_wide;
   logic signed [ACCWIDTH-1:0]  clamp_val;
   logic                        clamp_ovf;

   // One guard bit is enough: two in-range values can never overflow ACCWIDTH+1.
   always_comb begin
      sum_ext  = {{(ACCWIDTH + 1 - DATAWIDTH){bus.sum[DATAWIDTH-1]}}, bus.sum};
      acc_wide = {acc_q[ACCWIDTH-1], acc_q} + sum_ext;
   end

   sat_clamp #(.W(ACCWIDTH)) u_sat_clamp (
      .din  (acc_wide),
      .dout (clamp_val),
      .ovf  (clamp_ovf)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (bus.clr) begin
         state_d = ST_ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (bus.in_valid) begin
                  acc_d = clamp_val;
                  ovf_d = ovf_q | clamp_ovf;
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_q == LAST) begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               // Counter sits at COUNT here; it is cleared when the result leaves.
               if (bus.out_ready) begin
                  state_d = ST_ACCUM;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: begin
               state_d = ST_ACCUM;
            end
         endcase
      end
   end

   always_comb begin
      bus.in_ready  = (state_q == ST_ACCUM);
      bus.out_valid = (state_q == ST_DONE);
      bus.acc_out   = acc_q;
      bus.ovf       = ovf_q;
      state_dbg     = state_q;
   end
endmodule

// File: doc/sacc_stage.md
SACC_STAGE -- requirements
Module: sacc_stage

Interface
REQ-001 Parameter DATAWIDTH, default 8, width of incoming signed sample (two's complement).
REQ-002 Parameter ACCWIDTH, default 16, width of signed accumulator/result; SHALL be >= DATAWIDTH.
REQ-003 Parameter COUNT, default 4, samples per frame; SHALL be >= 1.
REQ-004 Clk  input  1  sole clock, all state updates on rising edge.
REQ-005 Rst  input  1  synchronous, active-high reset.
REQ-006 clr  input  1  synchronous frame abort.
REQ-007 in_valid  input  1  sample present on sum.
REQ-008 in_ready  output  1  stage accepts a sample this cycle.
REQ-009 sum  input  DATAWIDTH  signed sample, driven by the upstream signed adder.
REQ-010 out_valid  output  1  frame result present on acc_out.
REQ-011 out_ready  input  1  downstream accepts result this cycle.
REQ-012 acc_out  output  ACCWIDTH  signed saturated frame total.
REQ-013 ovf  output  1  frame saturated at least once; valid with out_valid.

Function
REQ-014 Two states: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-015 Input transfer occurs when in_valid && in_ready at a rising edge; output transfer when out_valid && out_ready.
REQ-016 In ACCUM, each input transfer SHALL set acc <= sat(acc + sext(sum)) and increment the sample counter.
REQ-017 sext SHALL sign-extend sum from DATAWIDTH to ACCWIDTH+1 bits; the sum SHALL be computed at ACCWIDTH+1 bits.
REQ-018 sat SHALL clamp to 2^(ACCWIDTH-1)-1 on positive overflow and -2^(ACCWIDTH-1) on negative overflow; either clamp SHALL set the sticky ovf register.
REQ-019 Accumulation SHALL continue from the clamped value for later samples in the frame.
REQ-020 On the COUNT-th input transfer the state SHALL go ACCUM->DONE; out_valid rises the cycle after that transfer (latency 1 cycle from last sample).
REQ-021 In DONE, acc_out and ovf SHALL hold stable until output transfer; in_valid SHALL be ignored.
REQ-022 On output transfer: state->ACCUM, acc<=0, counter<=0, ovf<=0, next cycle in_ready=1.
REQ-023 No same-cycle pass-through: in_ready SHALL not depend combinationally on out_ready.
REQ-024 acc_out SHALL be driven from the accumulator register in every state; value in ACCUM is the running partial sum.
REQ-025 clr SHALL, in any state, force state=ACCUM, acc=0, counter=0, ovf=0 next cycle, discarding any coincident input or pending result.
REQ-026 Counter SHALL be $clog2(COUNT+1) bits wide, wrap-free: reset to 0 on frame completion, never exceeds COUNT.
REQ-027 COUNT=1: every accepted sample SHALL produce a result frame.

Reset
REQ-028 Rst SHALL have priority over clr and all handshakes.
REQ-029 Rst SHALL set state=ACCUM, acc_out=0, counter=0, ovf=0, out_valid=0, in_ready=1 after the next rising edge.
REQ-030 Rst asserted mid-frame or in DONE SHALL discard all partial/pending data; no output transfer occurs in the Rst cycle.

Structure
REQ-031 State encoding (ACCUM, DONE) and saturation bound helpers SHALL live in the shared datapath package.
REQ-032 One sub-module SHALL exist: sat_clamp, combinational (ACCWIDTH+1)->ACCWIDTH signed clamp with an overflow flag output.
REQ-033 All state SHALL be in a single clocked process; handshake outputs SHALL decode from state only.

Verification (DATAWIDTH=8, ACCWIDTH=9, COUNT=4 unless noted)
REQ-034 Samples 10,-3,20,5 back-to-back, out_ready=1 -> one cycle after 4th: out_valid=1, acc_out=32, ovf=0; next cycle in_ready=1.
REQ-035 Samples 100,100,100,-50 -> partials 100,200,255(sat),205; result acc_out=205, ovf=1.
REQ-036 Samples -128,-128,-128,10 -> partials -128,-256,-256(sat),-246; acc_out=-246, ovf=1.
REQ-037 Result ready, out_ready=0 for 5 cycles with in_valid=1 -> acc_out stable, in_ready=0, no sample absorbed; out_ready=1 -> ovf clears, new frame starts at 0.
REQ-038 Two samples accepted then clr=1 coincident with in_valid=1 -> acc=0, counter=0; next 4 samples 1,1,1,1 -> acc_out=4.
REQ-039 Rst pulsed while DONE with out_ready=0 -> out_valid=0, acc_out=0, ovf=0, in_ready=1 after that edge; COUNT=1 run: sample 7 -> acc_out=7 next cycle.
